// File: rtl/trig_gen_pkg.sv
// Shared constants, link-word payload type and helpers for the trigger generator.
package trig_gen_pkg;

  localparam int unsigned WB_AW  = 3;
  localparam int unsigned WB_DW  = 32;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned WIN_W  = 8;
  localparam int unsigned MAJ_W  = 4;
  localparam int unsigned PRE_W  = 16;

  localparam logic [WORD_W-1:0] CH_COMMA = 16'h00BC;
  localparam logic [WORD_W-1:0] CH_TRIG  = 16'h801C;

  localparam logic [WB_AW-1:0] ADR_CSR   = 3'd0;
  localparam logic [WB_AW-1:0] ADR_CNT   = 3'd1;
  localparam logic [WB_AW-1:0] ADR_BLK   = 3'd2;
  localparam logic [WB_AW-1:0] ADR_PRESC = 3'd3;
  localparam logic [WB_AW-1:0] ADR_LOST  = 3'd4;

  localparam int unsigned CSR_EXT  = 16;
  localparam int unsigned CSR_SOFT = 17;
  localparam int unsigned CSR_AINC = 18;
  localparam int unsigned CSR_LCLR = 19;
  localparam int unsigned CSR_MAJ  = 20;
  localparam int unsigned BLK_WIN  = 16;

  // One word on the trigger link plus its K-flag
  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic              k;
  } link_t;

  // Population count of up to 16 flags
  function automatic logic [4:0] popcnt16(input logic [15:0] v);
    logic [4:0] s;
    s = 5'd0;
    for (int i = 0; i < 16; i++) s = s + 5'(v[i]);
    return s;
  endfunction

endpackage

// File: rtl/trig_gen_n_if.sv
// WishBone slave bus bundle for the trigger generator register file.
interface trig_gen_n_if;
  import trig_gen_pkg::*;

  logic             wb_cyc;
  logic             wb_stb;
  logic             wb_we;
  logic [WB_AW-1:0] wb_adr;
  logic [WB_DW-1:0] wb_dat_i;
  logic [WB_DW-1:0] wb_dat_o;
  logic             wb_ack;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_i,
    input  wb_dat_o, wb_ack
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_i,
    output wb_dat_o, wb_ack
  );
endinterface

// File: rtl/trig_coinc.sv
// Per-channel arm windows and majority coincidence over registered channel hits.
module trig_coinc
  import trig_gen_pkg::*;
#(
  parameter int unsigned NCH  = 4,
  parameter int unsigned WINW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    i_hit,
  input  logic [WINW-1:0]   i_win,
  input  logic [MAJ_W-1:0]  i_maj,
  output logic              o_cand_c
);

  logic [NCH-1:0][WINW-1:0] r_arm;
  logic [NCH-1:0]           w_armed;
  logic [4:0]               w_cnt;
  logic [4:0]               w_thr;

  // Armed set, its size, and the majority decision (M = 0 behaves as 1)
  always_comb begin
    w_armed = '0;
    for (int i = 0; i < int'(NCH); i++) w_armed[i] = i_hit[i] | (r_arm[i] != '0);
    w_cnt    = popcnt16(16'(w_armed));
    w_thr    = (i_maj == '0) ? 5'd1 : 5'(i_maj);
    o_cand_c = (w_cnt >= w_thr);
  end

  // Arm counters: flush on a candidate, reload on a hit, otherwise count down
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_arm <= '0;
    end else begin
      for (int i = 0; i < int'(NCH); i++) begin
        if (o_cand_c)           r_arm[i] <= '0;
        else if (i_hit[i])      r_arm[i] <= i_win;
        else if (r_arm[i] != '0) r_arm[i] <= r_arm[i] - WINW'(1);
      end
    end
  end

endmodule

// File: rtl/trig_gen_n.sv
// Trigger generator: channel coincidence, soft and external triggers, dead time,
// prescaling and WishBone-programmable registers driving a 16-bit trigger link.
module trig_gen_n
  import trig_gen_pkg::*;
#(
  parameter int unsigned NCH  = 4,
  parameter int unsigned BLKW = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [16*NCH-1:0]     trg_data_i,
  input  logic [NCH-1:0]        kchar_i,
  input  logic                  trg_ext,
  output logic [WORD_W-1:0]     trg_data_o,
  output logic                  kchar_o,
  trig_gen_n_if.slave           wb
);

  // Register file
  logic [NCH-1:0]   r_en;
  logic             r_ext_en;
  logic             r_soft;
  logic             r_autoinc;
  logic             r_lost_clr;
  logic [MAJ_W-1:0] r_maj;
  logic [31:0]      r_cnt;
  logic [BLKW-1:0]  r_blk_t;
  logic [WIN_W-1:0] r_win;
  logic [PRE_W-1:0] r_presc;
  logic [31:0]      r_lost;
  logic             r_ack;

  // Event stage and trigger state
  logic [NCH-1:0]   r_hit;
  logic             r_soft_q;
  logic [1:0]       r_sync;
  logic             r_sync_d;
  logic             r_ext_rise;
  logic [BLKW-1:0]  r_blk_cnt;
  logic [PRE_W-1:0] r_presc_cnt;
  link_t            r_link;

  logic [NCH-1:0]   w_hit;
  logic             w_wr;
  logic             w_chan_cand;
  logic             w_cand;
  logic             w_blk_idle;
  logic             w_emit;
  logic             w_unused_dat;

  assign w_wr         = wb.wb_cyc & wb.wb_stb & wb.wb_we;
  assign w_unused_dat = ^wb.wb_dat_i[WB_DW-1:24];
  assign wb.wb_ack    = r_ack;
  assign trg_data_o   = r_link.data;
  assign kchar_o      = r_link.k;

  // Bus acknowledge one cycle after a strobed cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ack <= 1'b0;
    else        r_ack <= wb.wb_cyc & wb.wb_stb;
  end

  // CSR, BLK and PRESC writes; soft trigger and LOST clear are one-cycle pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en       <= '0;
      r_ext_en   <= 1'b0;
      r_soft     <= 1'b0;
      r_autoinc  <= 1'b0;
      r_lost_clr <= 1'b0;
      r_maj      <= '0;
      r_blk_t    <= '0;
      r_win      <= '0;
      r_presc    <= '0;
    end else begin
      r_soft     <= 1'b0;
      r_lost_clr <= 1'b0;
      if (w_wr && wb.wb_adr == ADR_CSR) begin
        r_en       <= wb.wb_dat_i[NCH-1:0];
        r_ext_en   <= wb.wb_dat_i[CSR_EXT];
        r_soft     <= wb.wb_dat_i[CSR_SOFT];
        r_autoinc  <= wb.wb_dat_i[CSR_AINC];
        r_lost_clr <= wb.wb_dat_i[CSR_LCLR];
        r_maj      <= wb.wb_dat_i[CSR_MAJ +: MAJ_W];
      end
      if (w_wr && wb.wb_adr == ADR_BLK) begin
        r_blk_t <= wb.wb_dat_i[BLKW-1:0];
        r_win   <= wb.wb_dat_i[BLK_WIN +: WIN_W];
      end
      if (w_wr && wb.wb_adr == ADR_PRESC) r_presc <= wb.wb_dat_i[PRE_W-1:0];
    end
  end

  // Read mux, combinational on the address
  always_comb begin
    wb.wb_dat_o = '0;
    case (wb.wb_adr)
      ADR_CSR:   wb.wb_dat_o = {8'h00, r_maj, r_lost_clr, r_autoinc, r_soft, r_ext_en, 16'(r_en)};
      ADR_CNT:   wb.wb_dat_o = r_cnt;
      ADR_BLK:   wb.wb_dat_o = {8'h00, r_win, 16'(r_blk_t)};
      ADR_PRESC: wb.wb_dat_o = {16'h0000, r_presc};
      ADR_LOST:  wb.wb_dat_o = r_lost;
      default:   wb.wb_dat_o = '0;
    endcase
  end

  // Channel hit decode: enabled K-character carrying the trigger code
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < int'(NCH); i++)
      w_hit[i] = r_en[i] & kchar_i[i] & (trg_data_i[WORD_W*i +: WORD_W] == CH_TRIG);
  end

  // Event stage: registered hits, soft pulse and synchronised external rising edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit      <= '0;
      r_soft_q   <= 1'b0;
      r_sync     <= '0;
      r_sync_d   <= 1'b0;
      r_ext_rise <= 1'b0;
    end else begin
      r_hit      <= w_hit;
      r_soft_q   <= r_soft;
      r_sync     <= {r_sync[0], trg_ext};
      r_sync_d   <= r_sync[1];
      r_ext_rise <= r_ext_en & r_sync[1] & ~r_sync_d;
    end
  end

  trig_coinc #(
    .NCH  (NCH),
    .WINW (WIN_W)
  ) u_coinc (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_hit    (r_hit),
    .i_win    (r_win),
    .i_maj    (r_maj),
    .o_cand_c (w_chan_cand)
  );

  assign w_cand     = w_chan_cand | r_soft_q | r_ext_rise;
  assign w_blk_idle = (r_blk_cnt == '0);
  assign w_emit     = w_cand & w_blk_idle & (r_presc_cnt == r_presc);

  // Dead-time and prescale counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blk_cnt   <= '0;
      r_presc_cnt <= '0;
    end else begin
      if (w_emit)           r_blk_cnt <= r_blk_t;
      else if (!w_blk_idle) r_blk_cnt <= r_blk_cnt - BLKW'(1);
      if (w_cand && w_blk_idle)
        r_presc_cnt <= w_emit ? '0 : r_presc_cnt + PRE_W'(1);
    end
  end

  // Lost-candidate counter; clear beats a simultaneous increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       r_lost <= '0;
    else if (r_lost_clr)                              r_lost <= '0;
    else if (w_cand && !w_blk_idle && r_lost != '1)   r_lost <= r_lost + 32'd1;
  end

  // Trigger counter; a bus write beats auto-increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           r_cnt <= '0;
    else if (w_wr && wb.wb_adr == ADR_CNT) r_cnt <= wb.wb_dat_i;
    else if (w_emit && r_autoinc)         r_cnt <= r_cnt + 32'd1;
  end

  // Link output: trigger word for one cycle, comma otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_link <= '{data: CH_COMMA, k: 1'b1};
    end else if (w_emit) begin
      r_link <= '{data: {1'b1, r_cnt[14:0]}, k: 1'b0};
    end else begin
      r_link <= '{data: CH_COMMA, k: 1'b1};
    end
  end

endmodule
